q_table_update_engine: RTL and testbench

Q_TABLE_UPDATE_ENGINE -- requirements
Module: q_table_update_engine

---
 rtl/q_table_update_engine.sv | 190 +++++++++++++++++++
 tb/tb_q_table_update_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/q_table_update_engine.sv
// Q-table update engine: one Q-learning update per request.
// The engine scans the successor row for its maximum, computes the Bellman
// update in wide fixed point, saturates the result and writes it back.
module q_table_update_engine #(
  parameter int N_STATES  = 16,
  parameter int N_ACTIONS = 4,
  parameter int Q_W       = 16,
  parameter int FRAC      = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     state,
  input  logic [3:0]     action,
  input  logic [7:0]     next_state,
  input  logic [Q_W-1:0] reward,
  input  logic [Q_W-1:0] alpha,
  input  logic [Q_W-1:0] gamma,
  input  logic           terminal,
  output logic           out_valid,
  output logic [Q_W-1:0] out_q,
  output logic           out_err,
  input  logic [7:0]     rd_state,
  input  logic [3:0]     rd_action,
  output logic [Q_W-1:0] rd_q
);

  localparam int DEPTH = N_STATES * N_ACTIONS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = 2 * Q_W + 2;
  localparam logic [8:0] NS_LIM = 9'(N_STATES);
  localparam logic [4:0] NA_LIM = 5'(N_ACTIONS);
  localparam logic [3:0] LAST_A = 4'(N_ACTIONS - 1);
  localparam logic signed [IW-1:0] Q_MAX_X = {{(IW-Q_W+1){1'b0}}, {(Q_W-1){1'b1}}};
  localparam logic signed [IW-1:0] Q_MIN_X = {{(IW-Q_W+1){1'b1}}, {(Q_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, CALC, WB} fsm_t;

  // Flat table index; only meaningful for in-range (s, a).
  function automatic logic [IDX_W-1:0] idx_f(input logic [7:0] s, input logic [3:0] a);
    return IDX_W'(s) * IDX_W'(N_ACTIONS) + IDX_W'(a);
  endfunction

  function automatic logic in_range_f(input logic [7:0] s, input logic [3:0] a);
    return ({1'b0, s} < NS_LIM) && ({1'b0, a} < NA_LIM);
  endfunction

  fsm_t                  fsm_r, fsm_s;
  logic [7:0]            req_state_r, req_next_r;
  logic [3:0]            req_action_r, scan_idx_r;
  logic [Q_W-1:0]        reward_r, alpha_r, gamma_r;
  logic                  terminal_r, err_r, req_err_s;
  logic signed [Q_W-1:0] max_q_r, scan_val_s, q_old_s;
  logic [Q_W-1:0]        q_new_s;
  logic [Q_W-1:0]        q_tbl_r [DEPTH];
  logic signed [IW-1:0]  gamma_x_s, alpha_x_s, max_x_s, reward_x_s, q_old_x_s;
  logic signed [IW-1:0]  prod_g_s, target_s, delta_s, prod_a_s, q_new_x_s;

  // Idle flag and request range check.
  always_comb begin
    in_ready  = (fsm_r == IDLE);
    req_err_s = ({1'b0, state} >= NS_LIM) || ({1'b0, action} >= NA_LIM) ||
                (!terminal && ({1'b0, next_state} >= NS_LIM));
  end

  // Next-state logic: SCAN lasts one cycle per action.
  always_comb begin
    fsm_s = fsm_r;
    case (fsm_r)
      IDLE: if (in_valid) fsm_s = SCAN; else fsm_s = IDLE;
      SCAN: if (scan_idx_r == LAST_A) fsm_s = CALC; else fsm_s = SCAN;
      CALC: fsm_s = WB;
      WB:   fsm_s = IDLE;
      default: fsm_s = IDLE;
    endcase
  end

  // Scan read, old value fetch and the wide fixed-point update with saturation.
  always_comb begin
    scan_val_s = '0;
    q_old_s    = '0;
    if (!terminal_r && in_range_f(req_next_r, scan_idx_r)) begin
      scan_val_s = q_tbl_r[idx_f(req_next_r, scan_idx_r)];
    end else begin
      scan_val_s = '0;
    end
    if (!err_r) begin
      q_old_s = q_tbl_r[idx_f(req_state_r, req_action_r)];
    end else begin
      q_old_s = '0;
    end
    gamma_x_s  = {{(IW-Q_W){1'b0}}, gamma_r};
    alpha_x_s  = {{(IW-Q_W){1'b0}}, alpha_r};
    max_x_s    = {{(IW-Q_W){max_q_r[Q_W-1]}}, max_q_r};
    reward_x_s = {{(IW-Q_W){reward_r[Q_W-1]}}, reward_r};
    q_old_x_s  = {{(IW-Q_W){q_old_s[Q_W-1]}}, q_old_s};
    prod_g_s   = gamma_x_s * max_x_s;
    target_s   = reward_x_s + (prod_g_s >>> FRAC);
    delta_s    = target_s - q_old_x_s;
    prod_a_s   = alpha_x_s * delta_s;
    q_new_x_s  = q_old_x_s + (prod_a_s >>> FRAC);
    if (q_new_x_s > Q_MAX_X) begin
      q_new_s = Q_MAX_X[Q_W-1:0];
    end else if (q_new_x_s < Q_MIN_X) begin
      q_new_s = Q_MIN_X[Q_W-1:0];
    end else begin
      q_new_s = q_new_x_s[Q_W-1:0];
    end
  end

  // FSM state, request capture and running maximum over the successor row.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r        <= IDLE;
      req_state_r  <= 8'd0;
      req_next_r   <= 8'd0;
      req_action_r <= 4'd0;
      scan_idx_r   <= 4'd0;
      reward_r     <= '0;
      alpha_r      <= '0;
      gamma_r      <= '0;
      terminal_r   <= 1'b0;
      err_r        <= 1'b0;
      max_q_r      <= '0;
    end else begin
      fsm_r <= fsm_s;
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            req_state_r  <= state;
            req_next_r   <= next_state;
            req_action_r <= action;
            reward_r     <= reward;
            alpha_r      <= alpha;
            gamma_r      <= gamma;
            terminal_r   <= terminal;
            err_r        <= req_err_s;
            scan_idx_r   <= 4'd0;
            max_q_r      <= '0;
          end
        end
        SCAN: begin
          scan_idx_r <= scan_idx_r + 4'd1;
          if ((scan_idx_r == 4'd0) || (scan_val_s > max_q_r)) begin
            max_q_r <= scan_val_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: one-cycle strobe in WB, value held until the next WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_err   <= 1'b0;
    end else if (fsm_r == CALC) begin
      out_valid <= 1'b1;
      out_q     <= err_r ? '0 : q_new_s;
      out_err   <= err_r;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Table storage: cleared on reset, written on the edge entering WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_tbl_r[i] <= '0;
      end
    end else if ((fsm_r == CALC) && !err_r) begin
      q_tbl_r[idx_f(req_state_r, req_action_r)] <= q_new_s;
    end
  end

  // Combinational read port; out-of-range addresses read as zero.
  always_comb begin
    rd_q = '0;
    if (in_range_f(rd_state, rd_action)) begin
      rd_q = q_tbl_r[idx_f(rd_state, rd_action)];
    end else begin
      rd_q = '0;
    end
  end

endmodule

// File: tb/tb_q_table_update_engine.sv
// Testbench for q_table_update_engine: a request-level model of the table
// and result timing, a per-cycle compare process, and directed requests
// with hand-computed expected values.
module tb_q_table_update_engine;

  localparam int NS = 16;
  localparam int NA = 4;
  localparam int QW = 16;
  localparam int FR = 8;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, terminal, out_valid, out_err;
  logic [7:0]    state, next_state, rd_state;
  logic [3:0]    action, rd_action;
  logic [QW-1:0] reward, alpha, gamma, out_q, rd_q;

  q_table_update_engine #(.N_STATES(NS), .N_ACTIONS(NA), .Q_W(QW), .FRAC(FR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .state(state), .action(action), .next_state(next_state), .reward(reward),
    .alpha(alpha), .gamma(gamma), .terminal(terminal), .out_valid(out_valid),
    .out_q(out_q), .out_err(out_err), .rd_state(rd_state), .rd_action(rd_action),
    .rd_q(rd_q)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 1'b0;

  // Model state: table contents, busy countdown and pending/held result.
  longint mt [NS][NA];
  int     m_cnt = 0;
  longint m_last_q = 0;
  bit     m_last_err = 1'b0;
  longint m_pend_q = 0;
  bit     m_pend_err = 1'b0;
  int     m_pend_s = 0;
  int     m_pend_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_w(input longint v);
    logic [QW-1:0] t;
    t = v[QW-1:0];
    return 32'(t);
  endfunction

  function automatic longint mrd(input int s, input int a);
    if (s < NS && a < NA) return mt[s][a];
    else return 0;
  endfunction

  // Q-learning rule in plain integer arithmetic.
  function automatic longint model_update(input int s, input int a, input int ns,
                                          input longint rw, input longint al,
                                          input longint gm, input bit term);
    longint mx, qo, tg, dl, qn;
    qo = mt[s][a];
    if (term) mx = 0;
    else begin
      mx = mt[ns][0];
      for (int i = 1; i < NA; i++) if (mt[ns][i] > mx) mx = mt[ns][i];
    end
    tg = rw + ((gm * mx) >>> FR);
    dl = tg - qo;
    qn = qo + ((al * dl) >>> FR);
    if (qn > (2**(QW-1) - 1)) qn = 2**(QW-1) - 1;
    if (qn < -(2**(QW-1))) qn = -(2**(QW-1));
    return qn;
  endfunction

  // Model: accept when idle, busy for NA+2 cycles, result/write in the last one.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) for (int j = 0; j < NA; j++) mt[i][j] = 0;
      m_cnt = 0; m_last_q = 0; m_last_err = 1'b0;
    end else if (m_cnt == 0) begin
      if (in_valid) begin
        m_pend_err = (int'(state) >= NS) || (int'(action) >= NA) ||
                     (!terminal && int'(next_state) >= NS);
        m_pend_s = int'(state);
        m_pend_a = int'(action);
        if (m_pend_err) m_pend_q = 0;
        else m_pend_q = model_update(int'(state), int'(action), int'(next_state),
                                     longint'($signed(reward)), longint'(alpha),
                                     longint'(gamma), terminal);
        m_cnt = NA + 2;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        if (!m_pend_err) mt[m_pend_s][m_pend_a] = m_pend_q;
        m_last_q = m_pend_q;
        m_last_err = m_pend_err;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_cnt == 0));
      chk("out_valid", 32'(out_valid), 32'(m_cnt == 1));
      chk("out_q", 32'(out_q), to_w(m_last_q));
      chk("out_err", 32'(out_err), 32'(m_last_err));
      chk("rd_q", 32'(rd_q), to_w(mrd(int'(rd_state), int'(rd_action))));
    end
  end

  task automatic req(input string name, input int s, input int a, input int ns,
                     input logic [15:0] rw, input logic [15:0] al, input logic [15:0] gm,
                     input bit term, input logic [15:0] exp_q, input bit exp_err);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    state = 8'(s); action = 4'(a); next_state = 8'(ns); reward = rw;
    alpha = al; gamma = gm; terminal = term; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    chk({name, "_latency"}, 32'(lat), 32'(NA + 2));
    chk({name, "_q"}, 32'(out_q), 32'(exp_q));
    chk({name, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  task automatic rd_chk(input string name, input int s, input int a, input logic [15:0] exp);
    @(posedge clk); #1;
    rd_state = 8'(s); rd_action = 4'(a);
    @(negedge clk);
    chk(name, 32'(rd_q), 32'(exp));
  endtask

  task automatic sweep(input bit zero);
    for (int s = 0; s <= NS; s++) begin
      for (int a = 0; a <= NA; a++) begin
        @(posedge clk); #1;
        rd_state = 8'(s); rd_action = 4'(a);
        @(negedge clk);
        if (zero) chk("rd_after_reset", 32'(rd_q), 32'd0);
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int run, nruns, pulses;
    reset = 1'b1; in_valid = 1'b0; state = 8'd0; action = 4'd0; next_state = 8'd0;
    reward = 16'h0000; alpha = 16'h0000; gamma = 16'h0000; terminal = 1'b0;
    rd_state = 8'd0; rd_action = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);

    req("first", 0, 1, 4, 16'h0A00, 16'h0080, 16'h00E6, 1'b0, 16'h0500, 1'b0);
    rd_chk("rd_0_1_first", 0, 1, 16'h0500);
    req("repeat", 0, 1, 4, 16'h0A00, 16'h0080, 16'h00E6, 1'b0, 16'h0780, 1'b0);
    req("maxq_row0", 3, 2, 0, 16'h0000, 16'h0080, 16'h00E6, 1'b0, 16'h035E, 1'b0);
    req("terminal", 5, 0, 0, 16'h0100, 16'h0080, 16'h00E6, 1'b1, 16'h0080, 1'b0);
    req("saturate", 0, 1, 0, 16'h7FFF, 16'h0100, 16'h0100, 1'b0, 16'h7FFF, 1'b0);
    req("negative", 2, 3, 9, 16'hF000, 16'h0080, 16'h00E6, 1'b0, 16'hF800, 1'b0);
    req("floor", 6, 1, 9, 16'hFFFF, 16'h0080, 16'h00E6, 1'b0, 16'hFFFF, 1'b0);
    req("term_ns_oor", 1, 0, 200, 16'h0100, 16'h0080, 16'h00E6, 1'b1, 16'h0080, 1'b0);
    req("err_state", 16, 0, 0, 16'h0A00, 16'h0080, 16'h00E6, 1'b0, 16'h0000, 1'b1);
    req("err_action", 0, 4, 0, 16'h0A00, 16'h0080, 16'h00E6, 1'b0, 16'h0000, 1'b1);
    rd_chk("rd_0_1_after_err", 0, 1, 16'h7FFF);
    sweep(1'b0);

    // in_valid held high: each accept is followed by NA+2 busy cycles.
    run = 0; nruns = 0;
    @(posedge clk); #1;
    state = 8'd16; action = 4'd0; next_state = 8'd0; terminal = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (!in_ready) run++;
      else begin
        if (run > 0) begin
          chk("busy_len", 32'(run), 32'(NA + 2));
          nruns++;
        end
        run = 0;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    chk("accept_count", 32'(nruns), 32'd3);
    wait_idle();

    // Reset during SCAN aborts the request and clears the table.
    @(posedge clk); #1;
    state = 8'd0; action = 4'd1; next_state = 8'd4; reward = 16'h0A00;
    alpha = 16'h0080; gamma = 16'h00E6; terminal = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 32'd0);
    sweep(1'b1);

    req("fresh_terminal", 3, 2, 0, 16'h0000, 16'h0080, 16'h00E6, 1'b1, 16'h0000, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
